// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline register: control bundle, held entry and
// skid-buffer occupancy state. Saturating counter helper used when EXMEM_STATS_EN is defined.
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_W  = 5;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] result;
    logic                      zero;
    logic [DEFAULT_DATA_W-1:0] wdata;
    logic [DEFAULT_DATA_W-1:0] target;
    logic [DEFAULT_REG_W-1:0]  rd;
    ex_mem_ctrl_t              ctrl;
  } ex_mem_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: in_ready depends only on registered occupancy, so the upstream
// stage never sees a combinational path from out_ready. Occupancy is exported as state_o.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output pipe_state_t      state_o
);

  // Handshake: a beat moves on a side only in a cycle where valid and ready are both 1;
  // a producer holds valid and data stable until that cycle, ready never waits on valid.
  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid;
  logic             accept;
  logic             deliver;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = ~reset & (state_q != ST_TWO);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (deliver) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything, including a beat offered in the same cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_data = main_q;
  assign state_o  = state_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready on both sides, flush and registered branch decision.
// Define EXMEM_STATS_EN to implement the StallCnt/FlushCnt counters; otherwise they read 0.
module ex_mem_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DEFAULT_DATA_W,
  parameter int REG_W  = pipe_pkg::DEFAULT_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic              zero,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] PCBranch,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic [4:0]        Ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUresult_o,
  output logic [DATA_W-1:0] WriteData_o,
  output logic [DATA_W-1:0] PCBranch_o,
  output logic [REG_W-1:0]  WriteReg_o,
  output logic [4:0]        Ctrl_o,
  output logic              PCSrc,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
);

  // DATA_W/REG_W must match the pipe_pkg defaults that size ex_mem_entry_t.
  ex_mem_entry_t in_entry;
  ex_mem_entry_t out_entry;
  pipe_state_t   buf_state;

  assign in_entry = '{
    result: ALUresult,
    zero:   zero,
    wdata:  WriteData,
    target: PCBranch,
    rd:     WriteReg,
    ctrl:   ex_mem_ctrl_t'(Ctrl)
  };

  pipe_skid_buf #(
    .WIDTH($bits(ex_mem_entry_t))
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_ready (out_ready),
    .out_data  (out_entry),
    .state_o   (buf_state)
  );

  assign out_valid   = (buf_state != ST_EMPTY);
  assign ALUresult_o = out_entry.result;
  assign WriteData_o = out_entry.wdata;
  assign PCBranch_o  = out_entry.target;
  assign WriteReg_o  = out_entry.rd;
  assign Ctrl_o      = out_entry.ctrl;
  assign PCSrc       = out_valid & out_entry.ctrl.branch & out_entry.zero;

`ifdef EXMEM_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        flush_kills;

  // The main entry leaving in the flush cycle is delivered, not killed.
  assign flush_kills = flush & ((buf_state == ST_TWO) | ((buf_state == ST_ONE) & ~out_ready));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid & ~out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush_kills)            flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: reference model is a queue of held entries plus event counters,
// combined with a table of hand-computed vectors and directed skid/flush/reset/stall sequences.
module tb_ex_mem_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int EW = 3 * DW + 1 + RW + 5;  // {alu, zero, wdata, pcb, rd, ctrl}

`ifdef EXMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, zero, flush, out_valid, out_ready, PCSrc;
  logic [DW-1:0] ALUresult, WriteData, PCBranch, ALUresult_o, WriteData_o, PCBranch_o;
  logic [RW-1:0] WriteReg, WriteReg_o;
  logic [4:0]    Ctrl, Ctrl_o;
  logic [31:0]   StallCnt, FlushCnt;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic        z;
    logic [31:0] pcb;
    logic [4:0]  ctrl;
    logic        e_valid;
    logic        e_pcsrc;
    logic [31:0] e_alu;
    logic [31:0] e_pcb;
  } vec_t;
  vec_t vt[5];

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUresult   (ALUresult),
    .zero        (zero),
    .WriteData   (WriteData),
    .PCBranch    (PCBranch),
    .WriteReg    (WriteReg),
    .Ctrl        (Ctrl),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUresult_o (ALUresult_o),
    .WriteData_o (WriteData_o),
    .PCBranch_o  (PCBranch_o),
    .WriteReg_o  (WriteReg_o),
    .Ctrl_o      (Ctrl_o),
    .PCSrc       (PCSrc),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu, input logic z,
                        input logic [31:0] pcb, input logic [4:0] ctrl);
    in_valid  = v;
    ALUresult = alu;
    zero      = z;
    PCBranch  = pcb;
    Ctrl      = ctrl;
    WriteData = $urandom;
    WriteReg  = 5'($urandom_range(0, 31));
  endtask

  // Behaviour over one rising edge, computed from the current inputs.
  task automatic model_step();
    int sz  = exp_q.size();
    bit acc = in_valid && !reset && (sz < 2);
    bit dlv = (sz > 0) && out_ready;
    if (reset) begin
      exp_q.delete();
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
      if (sz > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) begin
        if ((sz - (dlv ? 1 : 0)) > 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
        exp_q.delete();
      end else begin
        if (dlv) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({ALUresult, zero, WriteData, PCBranch, WriteReg, Ctrl});
      end
    end
  endtask

  task automatic check_model();
    logic [EW-1:0] e;
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("in_ready", in_ready, !reset && exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("ALUresult_o", ALUresult_o, e[106:75]);
      chk("WriteData_o", WriteData_o, e[73:42]);
      chk("PCBranch_o", PCBranch_o, e[41:10]);
      chk("WriteReg_o", WriteReg_o, e[9:5]);
      chk("Ctrl_o", Ctrl_o, e[4:0]);
      chk("PCSrc", PCSrc, e[4] & e[74]);
    end else begin
      chk("PCSrc_idle", PCSrc, 1'b0);
    end
    chk("StallCnt", StallCnt, STATS ? m_stall : 32'd0);
    chk("FlushCnt", FlushCnt, STATS ? m_flush : 32'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (n) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_alu", ALUresult_o, 32'd0);
    chk("rst_pcb", PCBranch_o, 32'd0);
    chk("rst_ctrl", Ctrl_o, 5'd0);
    chk("rst_pcsrc", PCSrc, 1'b0);
    chk("rst_stall", StallCnt, 32'd0);
    chk("rst_flushcnt", FlushCnt, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 32'd0, 5'd0);

    vt[0] = '{1'b1, 32'h11,  1'b1, 32'h40,  5'b10000, 1'b1, 1'b1, 32'h11, 32'h40};
    vt[1] = '{1'b1, 32'h22,  1'b0, 32'h80,  5'b10010, 1'b1, 1'b0, 32'h22, 32'h80};
    vt[2] = '{1'b1, 32'h33,  1'b1, 32'hC0,  5'b00011, 1'b1, 1'b0, 32'h33, 32'hC0};
    vt[3] = '{1'b1, 32'h44,  1'b1, 32'h100, 5'b11000, 1'b1, 1'b1, 32'h44, 32'h100};
    vt[4] = '{1'b0, 32'h0,   1'b0, 32'h0,   5'b00000, 1'b0, 1'b0, 32'h0,  32'h0};

    // Streaming with out_ready held high: one-cycle latency, no bubbles.
    do_reset(2);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(vt[i].v, vt[i].alu, vt[i].z, vt[i].pcb, vt[i].ctrl);
      tick();
      chk("vec_valid", out_valid, vt[i].e_valid);
      chk("vec_in_ready", in_ready, 1'b1);
      chk("vec_pcsrc", PCSrc, vt[i].e_pcsrc);
      if (vt[i].e_valid) begin
        chk("vec_alu", ALUresult_o, vt[i].e_alu);
        chk("vec_pcb", PCBranch_o, vt[i].e_pcb);
      end
    end

    // Back-pressure fills the skid entry; release drains in order.
    do_reset(1);
    set_in(1'b1, 32'hA1, 1'b0, 32'h4, 5'd0);
    tick();
    chk("skid_a_alu", ALUresult_o, 32'hA1);
    set_in(1'b1, 32'hB2, 1'b0, 32'h8, 5'd0);
    tick();
    chk("skid_full_ready", in_ready, 1'b0);
    chk("skid_hold_a", ALUresult_o, 32'hA1);
    set_in(1'b1, 32'hC3, 1'b0, 32'hC, 5'd0);
    tick();
    chk("skid_still_a", ALUresult_o, 32'hA1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("skid_b_valid", out_valid, 1'b1);
    chk("skid_b_alu", ALUresult_o, 32'hB2);
    tick();
    chk("skid_drained", out_valid, 1'b0);

    // Flush while full, with a new beat offered in the same cycle.
    do_reset(1);
    set_in(1'b1, 32'h1, 1'b0, 32'h0, 5'd0);
    tick();
    set_in(1'b1, 32'h2, 1'b0, 32'h0, 5'd0);
    tick();
    flush = 1'b1;
    set_in(1'b1, 32'h3, 1'b0, 32'h0, 5'd0);
    tick();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_cnt", FlushCnt, STATS ? 32'd1 : 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_no_capture", out_valid, 1'b0);

    // Reset while full.
    out_ready = 1'b0;
    set_in(1'b1, 32'h55, 1'b1, 32'h40, 5'b10000);
    tick();
    set_in(1'b1, 32'h66, 1'b1, 32'h40, 5'b10000);
    tick();
    chk("pre_rst_full", in_ready, 1'b0);
    do_reset(1);

    // Ten cycles of stall with a valid entry.
    out_ready = 1'b1;
    set_in(1'b1, 32'h77, 1'b0, 32'h0, 5'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (10) tick();
    chk("stall_10", StallCnt, STATS ? 32'd10 : 32'd0);
    out_ready = 1'b1;
    tick();

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      set_in(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 1)),
             $urandom, 5'($urandom_range(0, 31)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
